// File: rtl/vram_pkg.sv
// Shared constants, register map and state encoding for the VRAM host controller.
package vram_pkg;

  localparam int unsigned VRAM_AW   = 13;
  localparam int unsigned VRAM_DW   = 8;
  localparam int unsigned VRAM_SIZE = 5120;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_FILL     = 2'd2
  } state_e;

  // Post-increment with wrap at the top of VRAM.
  function automatic logic [VRAM_AW-1:0] ptr_inc(input logic [VRAM_AW-1:0] p,
                                                  input int unsigned size);
    return (32'(p) == size - 32'd1) ? '0 : p + VRAM_AW'(1);
  endfunction

  // Out-of-range pointer values collapse to zero.
  function automatic logic [VRAM_AW-1:0] ptr_clip(input logic [VRAM_AW-1:0] p,
                                                   input int unsigned size);
    return (32'(p) >= size) ? '0 : p;
  endfunction

endpackage

// File: rtl/vram_host_ctrl.sv
// Host register window onto VRAM: auto-incrementing pointer, write-through DATA
// port, read-ahead buffer for DATA reads and a whole-memory FILL engine.
module vram_host_ctrl #(
  parameter int unsigned VRAM_SIZE = vram_pkg::VRAM_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   hostReg,
  input  logic [vram_pkg::VRAM_DW-1:0] hostWrData,
  input  logic                         hostWr,
  input  logic                         hostRd,
  output logic [vram_pkg::VRAM_DW-1:0] hostRdData,
  output logic                         hostBusy,
  output logic [vram_pkg::VRAM_AW-1:0] vramWrAddr,
  output logic [vram_pkg::VRAM_DW-1:0] vramWrData,
  output logic                         vramWr,
  output logic [vram_pkg::VRAM_AW-1:0] vramRdAddr2,
  input  logic [vram_pkg::VRAM_DW-1:0] vramRdData2
);
  import vram_pkg::*;

  localparam int unsigned LO_W = 8;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [VRAM_AW-1:0]   ptr_q, ptr_d;
  logic [VRAM_DW-1:0]   rd_buf_q, rd_buf_d;
  logic [VRAM_DW-1:0]   host_rd_data_q, host_rd_data_d;
  logic                 host_busy_q, host_busy_d;
  logic                 vram_wr_q, vram_wr_d;
  logic [VRAM_AW-1:0]   vram_wr_addr_q, vram_wr_addr_d;
  logic [VRAM_DW-1:0]   vram_wr_data_q, vram_wr_data_d;
  logic [VRAM_AW-1:0]   vram_rd_addr_q, vram_rd_addr_d;

  logic addr_wr, data_wr, ctrl_wr, rd_req;

  // A simultaneous write wins; the read is discarded.
  assign rd_req  = hostRd && !hostWr;
  assign addr_wr = hostWr && (hostReg == REG_ADDR_LO || hostReg == REG_ADDR_HI);
  assign data_wr = hostWr && (hostReg == REG_DATA);
  assign ctrl_wr = hostWr && (hostReg == REG_CTRL);

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    ptr_d          = ptr_q;
    rd_buf_d       = rd_buf_q;
    host_rd_data_d = host_rd_data_q;
    vram_wr_d      = 1'b0;
    vram_wr_addr_d = vram_wr_addr_q;
    vram_wr_data_d = vram_wr_data_q;
    vram_rd_addr_d = vram_rd_addr_q;

    if (addr_wr) begin
      if (hostReg == REG_ADDR_LO)
        ptr_d = ptr_clip({ptr_q[VRAM_AW-1:LO_W], hostWrData}, VRAM_SIZE);
      else
        ptr_d = ptr_clip({hostWrData[VRAM_AW-LO_W-1:0], ptr_q[LO_W-1:0]}, VRAM_SIZE);
    end

    if (rd_req) begin
      case (hostReg)
        REG_ADDR_LO: host_rd_data_d = ptr_q[LO_W-1:0];
        REG_ADDR_HI: host_rd_data_d = VRAM_DW'(ptr_q[VRAM_AW-1:LO_W]);
        REG_CTRL:    host_rd_data_d = VRAM_DW'(host_busy_q);
        REG_DATA: begin
          if (state_q == ST_IDLE) begin
            host_rd_data_d = rd_buf_q;
            ptr_d          = ptr_inc(ptr_q, VRAM_SIZE);
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (addr_wr || (rd_req && hostReg == REG_DATA)) begin
          state_d        = ST_PREFETCH;
          phase_d        = 1'b0;
          vram_rd_addr_d = ptr_d;
        end else if (data_wr) begin
          vram_wr_d      = 1'b1;
          vram_wr_addr_d = ptr_q;
          vram_wr_data_d = hostWrData;
          ptr_d          = ptr_inc(ptr_q, VRAM_SIZE);
          state_d        = ST_PREFETCH;
          phase_d        = 1'b0;
          vram_rd_addr_d = ptr_d;
        end else if (ctrl_wr) begin
          vram_wr_d      = 1'b1;
          vram_wr_addr_d = '0;
          vram_wr_data_d = hostWrData;
          state_d        = ST_FILL;
        end
      end

      // Phase 0 presents the address, phase 1 captures the returned byte.
      ST_PREFETCH: begin
        if (addr_wr) begin
          phase_d        = 1'b0;
          vram_rd_addr_d = ptr_d;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          rd_buf_d = vramRdData2;
          phase_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (vram_wr_addr_q == VRAM_AW'(VRAM_SIZE - 1)) begin
          state_d        = ST_PREFETCH;
          phase_d        = 1'b0;
          vram_rd_addr_d = ptr_d;
        end else begin
          vram_wr_d      = 1'b1;
          vram_wr_addr_d = vram_wr_addr_q + VRAM_AW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    host_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= 1'b0;
      ptr_q          <= '0;
      rd_buf_q       <= '0;
      host_rd_data_q <= '0;
      host_busy_q    <= 1'b0;
      vram_wr_q      <= 1'b0;
      vram_wr_addr_q <= '0;
      vram_wr_data_q <= '0;
      vram_rd_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      ptr_q          <= ptr_d;
      rd_buf_q       <= rd_buf_d;
      host_rd_data_q <= host_rd_data_d;
      host_busy_q    <= host_busy_d;
      vram_wr_q      <= vram_wr_d;
      vram_wr_addr_q <= vram_wr_addr_d;
      vram_wr_data_q <= vram_wr_data_d;
      vram_rd_addr_q <= vram_rd_addr_d;
    end
  end

  assign hostRdData  = host_rd_data_q;
  assign hostBusy    = host_busy_q;
  assign vramWr      = vram_wr_q;
  assign vramWrAddr  = vram_wr_addr_q;
  assign vramWrData  = vram_wr_data_q;
  assign vramRdAddr2 = vram_rd_addr_q;

endmodule

// File: tb/tb_vram_host_ctrl.sv
// Directed and randomized bench for vram_host_ctrl with a behavioural VRAM/pointer model.
module tb_vram_host_ctrl;

  localparam int unsigned SIZE = 5120;
  localparam logic [1:0] R_LO = 2'd0, R_HI = 2'd1, R_DATA = 2'd2, R_CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  hostReg = 2'd0;
  logic [7:0]  hostWrData = 8'd0;
  logic        hostWr = 1'b0;
  logic        hostRd = 1'b0;
  logic [7:0]  hostRdData;
  logic        hostBusy;
  logic [12:0] vramWrAddr;
  logic [7:0]  vramWrData;
  logic        vramWr;
  logic [12:0] vramRdAddr2;
  logic [7:0]  vramRdData2;

  always #5 clk = ~clk;

  vram_host_ctrl #(.VRAM_SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .hostReg(hostReg), .hostWrData(hostWrData),
    .hostWr(hostWr), .hostRd(hostRd), .hostRdData(hostRdData), .hostBusy(hostBusy),
    .vramWrAddr(vramWrAddr), .vramWrData(vramWrData), .vramWr(vramWr),
    .vramRdAddr2(vramRdAddr2), .vramRdData2(vramRdData2)
  );

  // Simple synchronous VRAM standing in for the mirrored memory.
  logic [7:0] vmem [0:8191];
  logic       mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8192; i++) vmem[i] <= 8'h00;
    end else if (vramWr) begin
      vmem[vramWrAddr] <= vramWrData;
    end
    vramRdData2 <= vmem[vramRdAddr2];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image, pointer and read-ahead byte.
  logic [7:0]  exp_mem [0:SIZE-1];
  int unsigned m_ptr;
  logic [7:0]  m_rdbuf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_inc(input int unsigned p);
    return (p == SIZE - 1) ? 0 : p + 1;
  endfunction

  function automatic int unsigned m_clip(input int unsigned p);
    return (p >= SIZE) ? 0 : p;
  endfunction

  task automatic host_wr(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    hostReg = r; hostWrData = d; hostWr = 1'b1;
    @(negedge clk);
    hostWr = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] r, output logic [7:0] d);
    @(negedge clk);
    hostReg = r; hostRd = 1'b1;
    @(negedge clk);
    hostRd = 1'b0;
    d = hostRdData;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (hostBusy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(hostBusy), 32'd0);
  endtask

  // Model-side effects of each host operation.
  task automatic m_set_lo(input logic [7:0] d);
    m_ptr   = m_clip((m_ptr & 32'h1F00) | 32'(d));
    m_rdbuf = exp_mem[m_ptr];
  endtask

  task automatic m_set_hi(input logic [7:0] d);
    m_ptr   = m_clip(((32'(d) & 32'h1F) << 8) | (m_ptr & 32'hFF));
    m_rdbuf = exp_mem[m_ptr];
  endtask

  task automatic m_data_wr(input logic [7:0] d);
    exp_mem[m_ptr] = d;
    m_ptr   = m_inc(m_ptr);
    m_rdbuf = exp_mem[m_ptr];
  endtask

  task automatic m_data_rd(output logic [7:0] d);
    d       = m_rdbuf;
    m_ptr   = m_inc(m_ptr);
    m_rdbuf = exp_mem[m_ptr];
  endtask

  task automatic do_lo(input logic [7:0] d);
    host_wr(R_LO, d); m_set_lo(d); wait_idle("idle_lo", 10);
  endtask

  task automatic do_hi(input logic [7:0] d);
    host_wr(R_HI, d); m_set_hi(d); wait_idle("idle_hi", 10);
  endtask

  task automatic check_ptr(input string tag);
    logic [7:0] lo, hi;
    host_rd(R_LO, lo);
    check({tag, "_ptr_lo"}, 32'(lo), m_ptr & 32'hFF);
    host_rd(R_HI, hi);
    check({tag, "_ptr_hi"}, 32'(hi), m_ptr >> 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(hostBusy),    32'd0);
    check({tag, "_wr"},     32'(vramWr),      32'd0);
    check({tag, "_wraddr"}, 32'(vramWrAddr),  32'd0);
    check({tag, "_wrdata"}, 32'(vramWrData),  32'd0);
    check({tag, "_rdaddr"}, 32'(vramRdAddr2), 32'd0);
    check({tag, "_rddata"}, 32'(hostRdData),  32'd0);
  endtask

  initial begin
    logic [7:0] rdv, expv;
    logic [7:0] held;
    int busy_cnt, wr_cnt, bad, mism;

    for (int i = 0; i < SIZE; i++) exp_mem[i] = 8'h00;
    m_ptr = 0; m_rdbuf = 8'h00;

    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Write through DATA at a chosen address.
    do_lo(8'h10);
    do_hi(8'h00);
    host_wr(R_DATA, 8'hAB);
    check("s1_vramwr",   32'(vramWr),     32'd1);
    check("s1_wraddr",   32'(vramWrAddr), 32'h0010);
    check("s1_wrdata",   32'(vramWrData), 32'hAB);
    check("s1_busy",     32'(hostBusy),   32'd1);
    m_data_wr(8'hAB);
    wait_idle("s1_idle", 10);
    check_ptr("s1");

    // Pointer wrap at the last byte.
    do_lo(8'hFF);
    do_hi(8'h13);
    host_wr(R_DATA, 8'h55);
    check("s2_wraddr", 32'(vramWrAddr), 32'h13FF);
    check("s2_wrdata", 32'(vramWrData), 32'h55);
    m_data_wr(8'h55);
    wait_idle("s2_idle", 10);
    check_ptr("s2");

    // Preload then read back through the prefetch buffer.
    do_lo(8'h20);
    host_wr(R_DATA, 8'h7E); m_data_wr(8'h7E); wait_idle("s3_idle_a", 10);
    do_lo(8'h20);
    host_rd(R_DATA, rdv); m_data_rd(expv);
    check("s3_rddata", 32'(rdv), 32'h7E);
    check("s3_model",  32'(rdv), 32'(expv));
    wait_idle("s3_idle_b", 10);
    check_ptr("s3");

    // Simultaneous write and read on DATA.
    do_lo(8'h20);
    host_rd(R_DATA, held); m_data_rd(expv);
    wait_idle("s4_idle_a", 10);
    @(negedge clk);
    hostReg = R_DATA; hostWrData = 8'hC3; hostWr = 1'b1; hostRd = 1'b1;
    @(negedge clk);
    hostWr = 1'b0; hostRd = 1'b0;
    check("s4_vramwr", 32'(vramWr),     32'd1);
    check("s4_wraddr", 32'(vramWrAddr), 32'h0021);
    check("s4_wrdata", 32'(vramWrData), 32'hC3);
    check("s4_rdhold", 32'(hostRdData), 32'h7E);
    m_data_wr(8'hC3);
    wait_idle("s4_idle_b", 10);

    // Out-of-range high byte forces the pointer to zero.
    do_hi(8'h1F);
    check_ptr("s5");
    host_rd(R_CTRL, rdv);
    check("s5_ctrl_idle", 32'(rdv), 32'd0);

    // Randomized mix of host operations against the model.
    for (int k = 0; k < 60; k++) begin
      int unsigned op;
      logic [7:0] d;
      op = $urandom_range(0, 4);
      case (op)
        0: do_lo(8'($urandom));
        1: do_hi({3'($urandom), 5'($urandom_range(0, 21))});
        2: begin
          d = 8'($urandom);
          host_wr(R_DATA, d); m_data_wr(d); wait_idle("rnd_idle_w", 10);
        end
        3: begin
          host_rd(R_DATA, rdv); m_data_rd(expv);
          check("rnd_rddata", 32'(rdv), 32'(expv));
          wait_idle("rnd_idle_r", 10);
        end
        default: check_ptr("rnd");
      endcase
    end

    // FILL: busy length, write sequence, dropped DATA write, CTRL read while busy.
    host_wr(R_CTRL, 8'h20);
    busy_cnt = 0; wr_cnt = 0; bad = 0;
    for (int cyc = 0; cyc < 6000 && hostBusy; cyc++) begin
      busy_cnt++;
      if (vramWr) begin
        if (32'(vramWrAddr) != 32'(wr_cnt) || vramWrData != 8'h20) bad++;
        wr_cnt++;
      end
      if (cyc == 100) begin hostReg = R_DATA; hostWrData = 8'h99; hostWr = 1'b1; end
      if (cyc == 101) hostWr = 1'b0;
      if (cyc == 200) begin hostReg = R_CTRL; hostRd = 1'b1; end
      if (cyc == 201) begin
        hostRd = 1'b0;
        check("fill_ctrl_rd", 32'(hostRdData), 32'd1);
      end
      @(negedge clk);
    end
    check("fill_busy_cycles", 32'(busy_cnt), 32'd5122);
    check("fill_writes",      32'(wr_cnt),   32'd5120);
    check("fill_seq_errors",  32'(bad),      32'd0);
    check("fill_idle",        32'(hostBusy), 32'd0);
    for (int i = 0; i < SIZE; i++) exp_mem[i] = 8'h20;
    m_rdbuf = exp_mem[m_ptr];
    mism = 0;
    for (int i = 0; i < SIZE; i++) if (vmem[i] != exp_mem[i]) mism++;
    check("fill_mem_mismatches", 32'(mism), 32'd0);
    check_ptr("fill");
    host_rd(R_DATA, rdv); m_data_rd(expv);
    check("fill_rddata", 32'(rdv), 32'h20);
    wait_idle("fill_idle_b", 10);

    // Reset in the middle of a FILL.
    host_wr(R_CTRL, 8'h3C);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midfill_rst");
    rst = 1'b0;
    m_ptr = 0; m_rdbuf = 8'h00;
    check("midfill_mem_written", 32'(vmem[5]),    32'h3C);
    check("midfill_mem_kept",    32'(vmem[4000]), 32'h20);
    check_ptr("midfill");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_host_ctrl.md
VRAM_HOST_CTRL -- requirements
Module: vram_host_ctrl

Interface
REQ-001 Parameter VRAM_SIZE, default 5120, is the number of VRAM bytes; valid addresses are 0..VRAM_SIZE-1.
REQ-002 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port hostReg, input, 2: register select (0=ADDR_LO, 1=ADDR_HI, 2=DATA, 3=CTRL).
REQ-005 Port hostWrData, input, 8: host write data.
REQ-006 Port hostWr, input, 1: one-cycle host write strobe.
REQ-007 Port hostRd, input, 1: one-cycle host read strobe.
REQ-008 Port hostRdData, output, 8: registered host read data.
REQ-009 Port hostBusy, output, 1: controller is not accepting DATA or CTRL accesses.
REQ-010 Port vramWrAddr, output, 13: shared VRAM write address.
REQ-011 Port vramWrData, output, 8: shared VRAM write data.
REQ-012 Port vramWr, output, 1: shared VRAM write enable.
REQ-013 Port vramRdAddr2, output, 13: host-side VRAM read address.
REQ-014 Port vramRdData2, input, 8: host-side VRAM read data, valid 1 cycle after its address.

Function
REQ-015 The block SHALL hold a 13-bit pointer ptr; ADDR_LO writes set ptr[7:0] and ADDR_HI writes set ptr[12:8] from hostWrData[4:0].
REQ-016 If an ADDR write yields ptr >= VRAM_SIZE, ptr SHALL become 0.
REQ-017 Increment rule: ptr == VRAM_SIZE-1 SHALL wrap to 0.
REQ-018 States SHALL be IDLE, PREFETCH, FILL.
REQ-019 In IDLE, a DATA write at cycle N SHALL drive vramWr=1, vramWrAddr=ptr and vramWrData=hostWrData at cycle N+1, then increment ptr and enter PREFETCH.
REQ-020 Any ADDR write, or a DATA write/read, SHALL enter PREFETCH.
REQ-021 PREFETCH SHALL drive vramRdAddr2=ptr for one cycle and capture vramRdData2 into rdBuf on the next cycle, then return to IDLE; hostBusy=1 throughout.
REQ-022 A DATA read SHALL return rdBuf on hostRdData in the cycle after hostRd, increment ptr, and prefetch.
REQ-023 A CTRL read SHALL return {7'b0, hostBusy}, is accepted in every state, and has no side effects.
REQ-024 A CTRL write of value V in IDLE SHALL enter FILL; FILL writes V to addresses 0..VRAM_SIZE-1, one per cycle, with vramWr=1; ptr is unchanged; FILL then enters PREFETCH.
REQ-025 While hostBusy=1, DATA and CTRL writes and DATA reads SHALL be dropped with no state change; ADDR writes SHALL update ptr and re-trigger PREFETCH on completion.
REQ-026 If hostWr and hostRd are high together, the write SHALL be serviced and the read ignored; hostRdData keeps its value.
REQ-027 vramWr SHALL never be asserted outside a DATA write cycle or FILL.
REQ-028 Register-0 reads SHALL return ptr[7:0], and register-1 reads SHALL return {3'b0, ptr[12:8]}.

Reset
REQ-029 On rst: state=IDLE, ptr=0, rdBuf=0, hostRdData=0, hostBusy=0, vramWr=0, vramWrAddr=0, vramWrData=0, vramRdAddr2=0.
REQ-030 Reset during FILL or PREFETCH SHALL abort it immediately; VRAM contents already written are left as-is.

Structure
REQ-031 Package vram_pkg SHALL hold VRAM_AW=13, VRAM_SIZE, the register index constants, and the state enum.
REQ-032 The block SHALL have no sub-modules; the parent instantiates vram_mirrored beside it and wires the write port and read port 2.

Verification
REQ-033 Scenario: write ADDR_LO=0x10, ADDR_HI=0x00, then DATA=0xAB -> vramWr pulse with addr 0x0010 and data 0xAB; ptr=0x0011.
REQ-034 Scenario: set ptr=0x13FF, write DATA=0x55 -> write at 0x13FF; ptr wraps to 0.
REQ-035 Scenario: preload 0x0020=0x7E, set ptr=0x0020, wait for hostBusy=0, read DATA -> 0x7E; ptr=0x0021.
REQ-036 Scenario: write CTRL=0x20 -> hostBusy for 5122 cycles; 5120 writes of 0x20 to 0..5119; a DATA write mid-fill is dropped.
REQ-037 Scenario: write ADDR_HI=0x1F -> ptr=0; assert rst mid-FILL -> all outputs at reset values the next cycle.
REQ-038 Scenario: hostWr and hostRd on DATA in the same cycle -> write is performed and hostRdData is unchanged.
